// File: rtl/gpio_in_cond_pkg.sv
// Shared helpers for the GPIO input conditioner and its prescaler.
// Holds the counter-width rule so every user of tick_gen sizes it the same way.
package gpio_in_cond_pkg;

    // Width of a 0..div-1 counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        int unsigned w;
        w = (div > 32'd1) ? $clog2(div) : 32'd1;
        return w;
    endfunction

endpackage

// File: rtl/gpio_in_cond_tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every TICK_DIV.
// Kept generic so timer and UART baud logic can reuse it.
module tick_gen
    import gpio_in_cond_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned    CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 32'd1);

    logic [CW-1:0] r_cnt;

    // Counter wraps after LAST; with TICK_DIV=1 it stays at 0 and ticks every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: 2-flop synchroniser, tick-sampled debounce,
// sticky rising-edge flags with write-one-to-clear, and a registered irq.
module gpio_in_cond
    import gpio_in_cond_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned STABLE   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic             irq
);

    logic             w_tick;
    logic [WIDTH-1:0] w_rise_nxt;
    logic             r_irq;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic              r_s1;
        logic              r_s2;
        logic [STABLE-2:0] r_hist;
        logic              r_level;
        logic              r_rise;
        logic [STABLE-1:0] w_win;
        logic              w_all1;
        logic              w_all0;
        logic              w_set;
        logic              w_clr;

        // Window is oldest history bit first, newest synchronised sample last.
        assign w_win  = {r_hist, r_s2};
        assign w_all1 = &w_win;
        assign w_all0 = ~|w_win;
        assign w_set  = w_tick & w_all1 & ~r_level;
        assign w_clr  = clr_en & clr_mask[gi];
        // Set dominates clear so a rising edge is never lost to a racing clear.
        assign w_rise_nxt[gi] = w_set | (r_rise & ~w_clr);

        // Synchroniser, debounce history, level and sticky flag for one pin.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_hist  <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
            end else begin
                r_s1 <= raw_in[gi];
                r_s2 <= r_s1;
                if (w_tick) begin
                    r_hist <= w_win[STABLE-2:0];
                    if (w_all1) begin
                        r_level <= 1'b1;
                    end else if (w_all0) begin
                        r_level <= 1'b0;
                    end else begin
                        r_level <= r_level;
                    end
                end
                r_rise <= w_rise_nxt[gi];
            end
        end

        assign level[gi] = r_level;
        assign rise[gi]  = r_rise;
    end

    // irq tracks the flag word on the same edge the flags update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_rise_nxt;
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Scoreboard bench for gpio_in_cond with TICK_DIV=4, STABLE=3, WIDTH=32.
// Stimulus queues per-cycle expectations; a negedge monitor pops and compares them.
module tb_gpio_in_cond;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned STABLE   = 3;

    typedef struct {
        int          cyc;
        logic [31:0] lvl;
        logic [31:0] rs;
        logic        irq;
        string       name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] raw_in;
    logic             clr_en;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic             irq;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t e;

    gpio_in_cond #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .STABLE   (STABLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .clr_en   (clr_en),
        .clr_mask (clr_mask),
        .level    (level),
        .rise     (rise),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle; stale entries count as misses.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || level !== e.lvl || rise !== e.rs || irq !== e.irq) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d due=%0d: got level=%h rise=%h irq=%b, want level=%h rise=%h irq=%b",
                         e.name, cyc, e.cyc, level, rise, irq, e.lvl, e.rs, e.irq);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance n edges, queueing the expected outputs after each edge.
    task automatic run(input int n, input logic [31:0] l, input logic [31:0] r,
                       input logic i, input string name);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            step();
            x.cyc  = cyc;
            x.lvl  = l;
            x.rs   = r;
            x.irq  = i;
            x.name = name;
            sb.push_back(x);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        raw_in   = 32'hFFFF_FFFF;
        clr_en   = 1'b0;
        clr_mask = 32'h0000_0000;

        // Reset held with all pins high.
        run(3, 32'h0, 32'h0, 1'b0, "reset");

        // Clean press on bit 0: edge 0 sees raw=0, raw[0] rises before edge 1.
        rst    = 1'b0;
        raw_in = 32'h0000_0000;
        run(1, 32'h0, 32'h0, 1'b0, "press_e0");
        raw_in = 32'h0000_0001;
        run(10, 32'h0, 32'h0, 1'b0, "press_early");
        run(1, 32'h1, 32'h1, 1'b1, "press");

        // Glitch on bit 5 for 6 cycles (edges 12..17).
        raw_in = 32'h0000_0021;
        run(6, 32'h1, 32'h1, 1'b1, "glitch_hi");
        raw_in = 32'h0000_0001;
        run(14, 32'h1, 32'h1, 1'b1, "glitch_lo");

        // Clears: zero mask, mask without bit 0, then bit 0.
        clr_en   = 1'b1;
        clr_mask = 32'h0000_0000;
        run(1, 32'h1, 32'h1, 1'b1, "clr_zero");
        clr_mask = 32'hFFFF_FFFE;
        run(1, 32'h1, 32'h1, 1'b1, "clr_other");
        clr_mask = 32'h0000_0001;
        run(1, 32'h1, 32'h0, 1'b0, "clr");
        clr_en   = 1'b0;
        clr_mask = 32'h0000_0000;

        // Release bit 0, let level fall at edge 47; rise stays clear.
        raw_in = 32'h0000_0000;
        run(12, 32'h1, 32'h0, 1'b0, "fall_hold");
        run(1, 32'h0, 32'h0, 1'b0, "fall");

        // Re-press bit 0; clear collides with the set at edge 59.
        raw_in = 32'h0000_0001;
        run(11, 32'h0, 32'h0, 1'b0, "rerise_early");
        clr_en   = 1'b1;
        clr_mask = 32'h0000_0001;
        run(1, 32'h1, 32'h1, 1'b1, "collision");
        clr_en   = 1'b0;
        clr_mask = 32'h0000_0000;
        run(1, 32'h1, 32'h1, 1'b1, "collision_hold");

        // Bit 2 raised; reset lands after its second tick.
        raw_in = 32'h0000_0005;
        run(7, 32'h1, 32'h1, 1'b1, "mid_pre");
        rst = 1'b1;
        run(1, 32'h0, 32'h0, 1'b0, "mid_rst");
        rst = 1'b0;
        run(11, 32'h0, 32'h0, 1'b0, "mid_post");
        run(1, 32'h5, 32'h5, 1'b1, "mid_level");

        // All bits together, then all released.
        rst    = 1'b1;
        raw_in = 32'h0000_0000;
        run(1, 32'h0, 32'h0, 1'b0, "rst2");
        rst = 1'b0;
        run(1, 32'h0, 32'h0, 1'b0, "all_e0");
        raw_in = 32'hFFFF_FFFF;
        run(10, 32'h0, 32'h0, 1'b0, "all_early");
        run(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "all_rise");
        raw_in = 32'h0000_0000;
        run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "all_fall_hold");
        run(2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "all_fall");

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
